nonce_sweep_controller: RTL and testbench
=========================================

// Module: nonce_sweep_controller
// PURPOSE
// Sequences the shared SHA computational block through a nonce sweep for the miner.
// - Latches a message prefix plus a nonce range, launches one hash per nonce and waits for completion.
// - Compares each digest against a target and stops on the first digest strictly below it.
// - Sits between the host/config interface and the single SHA core; it is the core's only driver.
// PARAMETERS
// MSG_W     440  width of SHA core input message ({prefix, nonce})
// NONCE_W   32   nonce width; prefix width = MSG_W-NONCE_W
// DIG_W     256  digest width
// TIMEOUT   255  max WAIT cycles per hash before the error state (core nominal ~230)
// PORTS
// clk            in   1              clock
// rst            in   1              reset; one clock; reset is synchronous and active-high
// start          in   1              1-cycle pulse: latch config and begin sweep (ignored unless IDLE/DONE/ERR)
// abort          in   1              stop sweep; return to IDLE next cycle
// prefix         in   MSG_W-NONCE_W  fixed message bits, latched on start
// nonce_first    in   NONCE_W        first nonce, inclusive
// nonce_last     in   NONCE_W        last nonce, inclusive
// target         in   DIG_W          success when digest < target (unsigned), latched on start
// sha_begin      out  1              to core beginComputation, 1-cycle pulse
// sha_msg        out  MSG_W          to core inputMsg = {prefix_q, nonce_q}, stable from LAUNCH to CHECK
// sha_done       in   1              from core computationComplete (level)
// sha_digest     in   DIG_W          from core SHAoutput, valid while sha_done=1
// busy           out  1              high in LAUNCH/WAIT/CHECK
// found          out  1              sticky: hit found, held until next start/abort/rst
// exhausted      out  1              sticky: range ended with no hit
// timeout_err    out  1              sticky: core failed to complete within TIMEOUT
// found_nonce    out  NONCE_W        nonce of the hit (valid when found)
// found_digest   out  DIG_W          digest of the hit (valid when found)
// hash_count     out  NONCE_W+1      hashes checked since last start (saturating)
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; sha_msg=0; latched config cleared.
// - States: IDLE, LAUNCH, WAIT, CHECK, DONE, ERR.
// - IDLE/DONE/ERR + start: latch prefix/target/nonce_first->nonce_q, nonce_last->last_q.
//   Clear found/exhausted/timeout_err/hash_count. Go to LAUNCH.
// - LAUNCH: sha_begin=1 for exactly this cycle; clear wait counter; go to WAIT.
// - WAIT: first cycle ignores sha_done (core needs one cycle to drop a stale done).
//   - Afterwards sha_done=1 -> CHECK.
//   - Counter reaching TIMEOUT with no done -> set timeout_err, go to ERR.
// - CHECK (1 cycle): register compare sha_digest < target_q; hash_count += 1 (saturates at all-ones).
//   - Hit: found=1, found_nonce=nonce_q, found_digest=sha_digest -> DONE.
//   - Miss and nonce_q==last_q: exhausted=1 -> DONE.
//   - Else: nonce_q += 1 (mod 2^NONCE_W) -> LAUNCH.
// - Per-hash overhead: LAUNCH + CHECK = 2 cycles beyond core latency.
// - Wrap: the range is inclusive, and the end test uses equality before increment.
//   - nonce_first > nonce_last sweeps through the 0xFFFFFFFF -> 0 wrap.
//   - nonce_first == nonce_last hashes exactly once.
// - Hit on the last nonce reports found=1, exhausted=0.
// - abort has priority over every transition, including start in the same cycle.
//   - Effect: IDLE next cycle; busy=0; sticky flags cleared; no further sha_begin.
//   - An in-flight core computation is abandoned; a later start relaunches cleanly.
// - start while busy is ignored. rst mid-sweep behaves as the reset state above.
// - sha_msg changes only on the start latch or in CHECK; it never changes in WAIT.
// TESTING
// Bench uses a behavioural SHA stub (done after N cycles, digest = f(nonce)) plus one run on the real core.
// 1 Real core: prefix=0, nonce 0..0, target=all-ones.
//   -> one sha_begin; found=1, found_nonce=0, hash_count=1.
// 2 Stub N=5: digest=nonce==7 ? 0 : all-ones; range 3..10, target=1.
//   -> found_nonce=7, hash_count=5, exactly 5 sha_begin pulses, 7 cycles apart.
// 3 Stub: no hit, range 0xFFFFFFFE..0x00000001.
//   -> nonces FFFFFFFE, FFFFFFFF, 0, 1 in order; exhausted=1, found=0, hash_count=4.
// 4 Stub never asserts done.
//   -> timeout_err=1 after TIMEOUT WAIT cycles; state ERR; busy=0; new start recovers.
// 5 abort 3 cycles into WAIT of a range 0..100.
//   -> busy=0 next cycle; no further sha_begin; flags 0.
//   -> a following start with range 0..0 completes normally.
// 6 Edge cases: start during busy ignored (sha_msg unchanged); start+abort same cycle -> stays IDLE.
//   -> rst mid-WAIT: all outputs 0 on the next clock.

Source files
------------

// File: rtl/nonce_sweep_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nonce_sweep_controller
// Description : Drives the single shared SHA core through an inclusive nonce
//               sweep. For each nonce it launches one hash and waits for the
//               core to finish. It then compares the digest against a latched
//               target and stops on the first digest strictly below it.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          1-cycle pulse: latch config, begin sweep (IDLE/DONE/ERR only)
//   abort          stop immediately, back to IDLE; beats every other transition
//   prefix         fixed upper message bits, latched on start
//   nonce_first    first nonce of the range (inclusive)
//   nonce_last     last nonce of the range (inclusive, wraps through 0)
//   target         success threshold, digest < target (unsigned)
//   sha_begin      1-cycle launch pulse to the core
//   sha_msg        {prefix, nonce} to the core, held from LAUNCH to CHECK
//   sha_done       core completion level
//   sha_digest     core digest, valid while sha_done is high
//   busy           high during LAUNCH/WAIT/CHECK
//   found          sticky hit flag
//   exhausted      sticky range-ended-without-hit flag
//   timeout_err    sticky core-timeout flag
//   found_nonce    nonce of the hit
//   found_digest   digest of the hit
//   hash_count     hashes checked since start (saturating)
//
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_sweep_controller #(
   parameter int MSG_W   = 440,
   parameter int NONCE_W = 32,
   parameter int DIG_W   = 256,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [MSG_W-NONCE_W-1:0] prefix,
   input  logic [NONCE_W-1:0]       nonce_first,
   input  logic [NONCE_W-1:0]       nonce_last,
   input  logic [DIG_W-1:0]         target,
   output logic                     sha_begin,
   output logic [MSG_W-1:0]         sha_msg,
   input  logic                     sha_done,
   input  logic [DIG_W-1:0]         sha_digest,
   output logic                     busy,
   output logic                     found,
   output logic                     exhausted,
   output logic                     timeout_err,
   output logic [NONCE_W-1:0]       found_nonce,
   output logic [DIG_W-1:0]         found_digest,
   output logic [NONCE_W:0]         hash_count
);

   localparam int                 c_PFX_W     = MSG_W - NONCE_W;
   localparam int                 c_CNT_W     = $clog2(TIMEOUT + 1);
   // The wait counter holds the number of WAIT cycles already spent, so the
   // TIMEOUT-th WAIT cycle is the one that sees TIMEOUT-1.
   localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   state_t               r_state;
   logic [c_PFX_W-1:0]   r_prefix;
   logic [NONCE_W-1:0]   r_nonce;
   logic [NONCE_W-1:0]   r_last;
   logic [DIG_W-1:0]     r_target;
   logic [c_CNT_W-1:0]   r_wait_cnt;
   logic                 r_sha_begin;
   logic                 r_busy;
   logic                 r_found;
   logic                 r_exhausted;
   logic                 r_timeout_err;
   logic [NONCE_W-1:0]   r_found_nonce;
   logic [DIG_W-1:0]     r_found_digest;
   logic [NONCE_W:0]     r_hash_count;

   logic                 w_hit;
   logic [NONCE_W:0]     w_count_inc;

   assign w_hit       = (sha_digest < r_target);
   assign w_count_inc = (&r_hash_count) ? r_hash_count : r_hash_count + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_prefix       <= '0;
         r_nonce        <= '0;
         r_last         <= '0;
         r_target       <= '0;
         r_wait_cnt     <= '0;
         r_sha_begin    <= 1'b0;
         r_busy         <= 1'b0;
         r_found        <= 1'b0;
         r_exhausted    <= 1'b0;
         r_timeout_err  <= 1'b0;
         r_found_nonce  <= '0;
         r_found_digest <= '0;
         r_hash_count   <= '0;
      end else if (abort) begin
         // Any in-flight core work is simply abandoned; the next launch
         // restarts the core from scratch.
         r_state       <= S_IDLE;
         r_sha_begin   <= 1'b0;
         r_busy        <= 1'b0;
         r_found       <= 1'b0;
         r_exhausted   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_prefix      <= prefix;
                  r_target      <= target;
                  r_nonce       <= nonce_first;
                  r_last        <= nonce_last;
                  r_found       <= 1'b0;
                  r_exhausted   <= 1'b0;
                  r_timeout_err <= 1'b0;
                  r_hash_count  <= '0;
                  r_busy        <= 1'b1;
                  r_sha_begin   <= 1'b1;
                  r_state       <= S_LAUNCH;
               end
            end

            S_LAUNCH: begin
               r_sha_begin <= 1'b0;
               r_wait_cnt  <= '0;
               r_state     <= S_WAIT;
            end

            S_WAIT: begin
               if (r_wait_cnt == '0) begin
                  // The core may still show done from the previous hash
                  // during its first cycle, so the first WAIT cycle skips it.
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end else if (sha_done) begin
                  r_state <= S_CHECK;
               end else if (r_wait_cnt == c_WAIT_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= S_ERR;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end

            S_CHECK: begin
               r_hash_count <= w_count_inc;
               if (w_hit) begin
                  r_found        <= 1'b1;
                  r_found_nonce  <= r_nonce;
                  r_found_digest <= sha_digest;
                  r_busy         <= 1'b0;
                  r_state        <= S_DONE;
               end else if (r_nonce == r_last) begin
                  // End test happens before the increment, which is what
                  // makes the range inclusive and lets it wrap through zero.
                  r_exhausted <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_DONE;
               end else begin
                  r_nonce     <= r_nonce + 1'b1;
                  r_sha_begin <= 1'b1;
                  r_state     <= S_LAUNCH;
               end
            end

            default: begin
               r_sha_begin <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign sha_begin    = r_sha_begin;
   assign sha_msg      = {r_prefix, r_nonce};
   assign busy         = r_busy;
   assign found        = r_found;
   assign exhausted    = r_exhausted;
   assign timeout_err  = r_timeout_err;
   assign found_nonce  = r_found_nonce;
   assign found_digest = r_found_digest;
   assign hash_count   = r_hash_count;

endmodule
`default_nettype wire

// File: tb/tb_nonce_sweep_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nonce_sweep_controller
// Description : Self-checking bench for nonce_sweep_controller. A behavioural
//               SHA stub raises done a set number of cycles after each launch.
//               Its digest is a simple function of the launched nonce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonce_sweep_controller;

   localparam int MSG_W   = 440;
   localparam int NONCE_W = 32;
   localparam int DIG_W   = 256;
   localparam int PFX_W   = MSG_W - NONCE_W;
   localparam int TO      = 20;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [PFX_W-1:0]   prefix = '0;
   logic [NONCE_W-1:0] nonce_first = '0;
   logic [NONCE_W-1:0] nonce_last = '0;
   logic [DIG_W-1:0]   target = '0;
   logic               sha_begin;
   logic [MSG_W-1:0]   sha_msg;
   logic               sha_done;
   logic [DIG_W-1:0]   sha_digest;
   logic               busy;
   logic               found;
   logic               exhausted;
   logic               timeout_err;
   logic [NONCE_W-1:0] found_nonce;
   logic [DIG_W-1:0]   found_digest;
   logic [NONCE_W:0]   hash_count;

   always #5 clk = ~clk;

   nonce_sweep_controller #(
      .MSG_W   (MSG_W),
      .NONCE_W (NONCE_W),
      .DIG_W   (DIG_W),
      .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .prefix       (prefix),
      .nonce_first  (nonce_first),
      .nonce_last   (nonce_last),
      .target       (target),
      .sha_begin    (sha_begin),
      .sha_msg      (sha_msg),
      .sha_done     (sha_done),
      .sha_digest   (sha_digest),
      .busy         (busy),
      .found        (found),
      .exhausted    (exhausted),
      .timeout_err  (timeout_err),
      .found_nonce  (found_nonce),
      .found_digest (found_digest),
      .hash_count   (hash_count)
   );

   // ---------------- SHA stub ----------------
   // digest_mode 0: nonce==7 -> 0 else all-ones; 1: all-ones; 2: zero-extended nonce
   int                 stub_lat    = 5;
   int                 digest_mode = 0;
   bit                 stub_en     = 1'b1;
   int                 stub_cnt    = 0;
   logic [NONCE_W-1:0] stub_nonce  = '0;

   always @(posedge clk) begin
      if (sha_begin) begin
         stub_cnt   <= stub_en ? stub_lat : -1;
         stub_nonce <= sha_msg[NONCE_W-1:0];
      end else if (stub_cnt > 1) begin
         stub_cnt <= stub_cnt - 1;
      end
   end

   assign sha_done = (stub_cnt == 1);

   always_comb begin
      sha_digest = '1;
      case (digest_mode)
         0:       sha_digest = (stub_nonce == 32'd7) ? '0 : '1;
         1:       sha_digest = '1;
         default: sha_digest = DIG_W'(stub_nonce);
      endcase
   end

   // ---------------- launch monitor ----------------
   int                 cyc = 0;
   logic [NONCE_W-1:0] begin_nonces[$];
   int                 begin_times[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (sha_begin) begin
         begin_nonces.push_back(sha_msg[NONCE_W-1:0]);
         begin_times.push_back(cyc);
      end
   end

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [DIG_W-1:0] act, input logic [DIG_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input logic [NONCE_W-1:0] f, input logic [NONCE_W-1:0] l,
                              input logic [DIG_W-1:0] tgt, input logic [PFX_W-1:0] pfx);
      @(negedge clk);
      nonce_first = f;
      nonce_last  = l;
      target      = tgt;
      prefix      = pfx;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk(name, DIG_W'(busy), '0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},  DIG_W'(busy), '0);
      chk({tag, "_begin"}, DIG_W'(sha_begin), '0);
      chk({tag, "_msg"},   DIG_W'(sha_msg), '0);
      chk({tag, "_flags"}, DIG_W'({found, exhausted, timeout_err}), '0);
      chk({tag, "_fnonce"}, DIG_W'(found_nonce), '0);
      chk({tag, "_fdig"},  found_digest, '0);
      chk({tag, "_count"}, DIG_W'(hash_count), '0);
   endtask

   typedef struct {
      int                 mode;
      int                 lat;
      logic [NONCE_W-1:0] first;
      logic [NONCE_W-1:0] last;
      logic [DIG_W-1:0]   tgt;
      bit                 e_found;
      bit                 e_exh;
      logic [NONCE_W-1:0] e_nonce;
      logic [DIG_W-1:0]   e_dig;
      int                 e_cnt;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int                 base;
      int                 k;
      logic [MSG_W-1:0]   msg_hold;
      logic [NONCE_W-1:0] wrap_exp[4];

      vecs[0] = '{2, 1, 32'd0,          32'd0,  {DIG_W{1'b1}}, 1, 0, 32'd0,  '0,         1};
      vecs[1] = '{0, 5, 32'd3,          32'd10, DIG_W'(1),     1, 0, 32'd7,  '0,         5};
      vecs[2] = '{1, 3, 32'hFFFF_FFFE,  32'd1,  {DIG_W{1'b1}}, 0, 1, 32'd0,  '0,         4};
      vecs[3] = '{0, 2, 32'd7,          32'd7,  DIG_W'(1),     1, 0, 32'd7,  '0,         1};
      vecs[4] = '{2, 2, 32'd5,          32'd9,  DIG_W'(5),     0, 1, 32'd0,  '0,         5};
      vecs[5] = '{2, 2, 32'd5,          32'd9,  DIG_W'(6),     1, 0, 32'd5,  DIG_W'(5),  1};
      vecs[6] = '{0, 4, 32'd0,          32'd7,  DIG_W'(1),     1, 0, 32'd7,  '0,         8};
      wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};

      // reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset");

      // table-driven sweeps
      for (int i = 0; i < 7; i++) begin
         digest_mode = vecs[i].mode;
         stub_lat    = vecs[i].lat;
         base        = begin_nonces.size();
         pulse_start(vecs[i].first, vecs[i].last, vecs[i].tgt, PFX_W'(i + 1));
         wait_idle($sformatf("v%0d_end", i));
         chk($sformatf("v%0d_found", i), DIG_W'(found), DIG_W'(vecs[i].e_found));
         chk($sformatf("v%0d_exh", i),   DIG_W'(exhausted), DIG_W'(vecs[i].e_exh));
         chk($sformatf("v%0d_to", i),    DIG_W'(timeout_err), '0);
         chk($sformatf("v%0d_cnt", i),   DIG_W'(hash_count), DIG_W'(vecs[i].e_cnt));
         chk($sformatf("v%0d_begins", i), DIG_W'(begin_nonces.size() - base), DIG_W'(vecs[i].e_cnt));
         if (vecs[i].e_found) begin
            chk($sformatf("v%0d_fnonce", i), DIG_W'(found_nonce), DIG_W'(vecs[i].e_nonce));
            chk($sformatf("v%0d_fdig", i),   found_digest, vecs[i].e_dig);
         end
         if (i == 1) begin
            for (int j = 1; j < vecs[i].e_cnt && base + j < begin_times.size(); j++)
               chk($sformatf("v1_spacing%0d", j),
                   DIG_W'(begin_times[base + j] - begin_times[base + j - 1]), DIG_W'(7));
         end
         if (i == 2) begin
            for (int j = 0; j < 4 && base + j < begin_nonces.size(); j++)
               chk($sformatf("v2_wrap%0d", j), DIG_W'(begin_nonces[base + j]), DIG_W'(wrap_exp[j]));
         end
      end

      // timeout: core never completes
      stub_en = 1'b0;
      base    = begin_nonces.size();
      pulse_start(32'd0, 32'd3, {DIG_W{1'b1}}, '0);
      k = 0;
      while (!timeout_err && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("to_latency", DIG_W'(k), DIG_W'(TO + 1));
      chk("to_flag",    DIG_W'(timeout_err), DIG_W'(1));
      chk("to_busy",    DIG_W'(busy), '0);
      chk("to_begins",  DIG_W'(begin_nonces.size() - base), DIG_W'(1));
      stub_en     = 1'b1;
      digest_mode = 2;
      stub_lat    = 2;
      pulse_start(32'd0, 32'd0, {DIG_W{1'b1}}, '0);
      wait_idle("to_recover_end");
      chk("to_recover", DIG_W'({found, exhausted, timeout_err}), DIG_W'(3'b100));

      // abort three cycles into WAIT
      digest_mode = 1;
      stub_lat    = 5;
      pulse_start(32'd0, 32'd100, {DIG_W{1'b1}}, PFX_W'(32'hABCD));
      chk("ab_msg", DIG_W'(sha_msg), DIG_W'({PFX_W'(32'hABCD), 32'd0}));
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_busy",  DIG_W'(busy), '0);
      chk("ab_flags", DIG_W'({found, exhausted, timeout_err}), '0);
      base = begin_nonces.size();
      repeat (20) @(negedge clk);
      chk("ab_no_begin", DIG_W'(begin_nonces.size() - base), '0);
      digest_mode = 2;
      stub_lat    = 3;
      pulse_start(32'd0, 32'd0, {DIG_W{1'b1}}, '0);
      wait_idle("ab_recover_end");
      chk("ab_recover_found", DIG_W'(found), DIG_W'(1));
      chk("ab_recover_cnt",   DIG_W'(hash_count), DIG_W'(1));

      // start while busy is ignored
      digest_mode = 1;
      stub_lat    = 5;
      pulse_start(32'd0, 32'd5, {DIG_W{1'b1}}, PFX_W'(32'h1111));
      @(negedge clk);
      msg_hold = sha_msg;
      pulse_start(32'd50, 32'd60, '0, PFX_W'(32'h2222));
      chk("busy_start_msg",  DIG_W'(sha_msg), DIG_W'(msg_hold));
      chk("busy_start_busy", DIG_W'(busy), DIG_W'(1));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // start and abort in the same cycle
      base  = begin_nonces.size();
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", DIG_W'(busy), '0);
      repeat (5) @(negedge clk);
      chk("sa_no_begin", DIG_W'(begin_nonces.size() - base), '0);

      // rst mid-WAIT after a prior hit
      digest_mode = 2;
      stub_lat    = 2;
      pulse_start(32'd5, 32'd9, DIG_W'(6), PFX_W'(7));
      wait_idle("rst_pre_end");
      chk("rst_pre_found", DIG_W'(found_nonce), DIG_W'(5));
      digest_mode = 1;
      stub_lat    = 8;
      pulse_start(32'h10, 32'h20, {DIG_W{1'b1}}, PFX_W'(32'h5555));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("rst_mid");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
`default_nettype wire
